pe_input_buffer: RTL and testbench
==================================

// Module: pe_input_buffer
// PURPOSE
// - Elastic per-operand input queue between one NoC input channel and one operand input of the PE ucore.
// - Absorbs NoC backpressure and decouples NoC timing from ucore firing; one instance per PE operand port.
// - Valid/ready on both sides. No combinational path from out_ready to in_ready.
// PARAMETERS
// - DATA_WIDTH  32  payload width in bits
// - DEPTH       2   entries; power of two, >= 2
// - CNT_W       $clog2(DEPTH+1)  occupancy width (derived, not overridden)
// PORTS
// - clk         in   1           clock; all state on rising edge
// - rst         in   1           async reset, active-high
// - clear       in   1           sync flush (driven from ctrl_clear)
// - in_valid    in   1           NoC data valid
// - in_data     in   DATA_WIDTH  NoC payload
// - in_ready    out  1           buffer can accept (to NoC)
// - out_valid   out  1           operand available (to ucore)
// - out_data    out  DATA_WIDTH  operand payload
// - out_ready   in   1           ucore consumes operand
// - occupancy   out  CNT_W       stored entry count, 0..DEPTH
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
// - Reset (async assert): wr_ptr=rd_ptr=0, occupancy=0, out_valid=0, out_data=0, in_ready=1. Storage array is not reset.
// - push = in_valid & in_ready; pop = out_valid & out_ready.
// - in_ready = (occupancy != DEPTH). Depends only on registered state.
// - out_valid = (occupancy != 0); out_data = out_valid ? mem[rd_ptr] : '0.
// - Latency: a push at edge N is visible on out_valid/out_data after edge N (1 cycle).
// - Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally. Order is strict FIFO.
// - Push only: occupancy+1. Pop only: occupancy-1. Push and pop together: occupancy unchanged, both pointers advance.
// - Full (occupancy==DEPTH): in_ready=0, so no push. A pop in the same cycle is honoured; in_ready rises the next cycle.
// - Empty: out_valid=0, so no pop. A push is honoured.
// - in_valid without in_ready: no state change. The NoC holds in_data stable (upstream obligation).
// - clear=1: next edge sets pointers and occupancy to 0. Clear has priority over a same-cycle push/pop; that push is dropped.
// - Reset mid-operation: all entries are discarded immediately (async). Outputs take reset values in the same cycle.
// - No state machine beyond the counter. Occupancy never exceeds DEPTH and never underflows (guaranteed by the handshake).
// CONFIGURATION
// - Macro PE_INPUT_BUFFER_BYPASS_EN.
// - Defined: when occupancy==0, out_valid=in_valid and out_data=in_data (combinational). If out_ready is also 1 that cycle,
//   the word passes through with 0-cycle latency and is not written (occupancy stays 0). If out_ready=0, the word is
//   written normally. in_ready is still registered-only, so there is no ready loop.
// - Undefined: no bypass; minimum latency is 1 cycle as above.
// - Reset values are identical in both builds.
// TESTING
// - Reset: assert rst mid-stream with occupancy=2 -> same cycle occupancy=0, out_valid=0, out_data=0, in_ready=1.
// - Fill/drain: DEPTH=4, out_ready=0, push A1..A4 -> in_ready=0 after 4th, occupancy=4; push A5 refused;
//   then out_ready=1 -> A1..A4 emitted in order; in_ready=1 one cycle after the first pop.
// - Full + simultaneous: occupancy=4, in_valid=1, out_ready=1 -> pop only that cycle, occupancy=3; push accepted
//   the next cycle, occupancy stays 3 thereafter.
// - Steady stream: in_valid=out_ready=1 for 100 cycles, DEPTH=2 -> one word per cycle, occupancy constant,
//   wrap-around order correct (payload = counter).
// - Clear priority: occupancy=3, clear=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, pushed word absent.
// - Bypass (macro defined): empty, in_valid=1, in_data=32'hDEAD_BEEF, out_ready=1 -> same cycle out_valid=1,
//   out_data=DEADBEEF, occupancy stays 0. Without the macro: out_valid=0 that cycle, 1 the next.

Source files
------------

// File: rtl/pe_input_buffer.sv
// Elastic per-operand input FIFO between a NoC input channel and a PE ucore operand port.
// Optional combinational bypass when empty: define PE_INPUT_BUFFER_BYPASS_EN.
module pe_input_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      occ_q;
  logic                  empty, full;
  logic                  push, pop, bypass, wr_en, rd_en;

  assign empty     = (occ_q == '0);
  assign full      = (occ_q == CNT_W'(DEPTH));
  // in_ready comes from registered state only, so out_ready never reaches it.
  assign in_ready  = ~full;
  assign occupancy = occ_q;

`ifdef PE_INPUT_BUFFER_BYPASS_EN
  assign bypass    = empty & in_valid & out_ready;
  assign out_valid = ~empty | in_valid;
  assign out_data  = !empty ? mem[rd_ptr_q] : (in_valid ? in_data : '0);
`else
  assign bypass    = 1'b0;
  assign out_valid = ~empty;
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
`endif

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  // A bypassed word never touches storage or the counter.
  assign wr_en = push & ~bypass;
  assign rd_en = pop & ~bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   occ_q <= occ_q + CNT_W'(1);
        2'b01:   occ_q <= occ_q - CNT_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_pe_input_buffer.sv
// Self-checking bench for pe_input_buffer: DEPTH=4 and DEPTH=2 instances share stimulus and
// are compared every cycle against queue models; directed literal checks pin the models.
module tb_pe_input_buffer;

`ifdef PE_INPUT_BUFFER_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        ir [2];
  logic        ov [2];
  logic [31:0] od [2];
  logic [2:0]  oc [2];
  logic [2:0]  oc4;
  logic [1:0]  oc2;

  int total = 0;
  int bad = 0;
  int pops = 0;
  bit started = 1'b0;
  bit stream_on = 1'b0;

  logic [31:0] mq [2][$];
  int          dep [2] = '{4, 2};

  always #5 clk = ~clk;

  pe_input_buffer #(.DATA_WIDTH(32), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .occupancy(oc4)
  );

  pe_input_buffer #(.DATA_WIDTH(32), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .occupancy(oc2)
  );

  assign oc[0] = oc4;
  assign oc[1] = {1'b0, oc2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a bounded queue per instance, updated by the handshake rules.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || clear) begin
        mq[i].delete();
      end else begin
        int  sz;
        bit  byp, do_pop, do_push;
        sz      = mq[i].size();
        byp     = Byp && sz == 0 && in_valid && out_ready;
        do_pop  = sz != 0 && out_ready;
        do_push = in_valid && sz != dep[i];
        if (!byp) begin
          if (do_pop) void'(mq[i].pop_front());
          if (do_push) mq[i].push_back(in_data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        int          sz;
        logic [31:0] ed;
        sz = mq[i].size();
        if (sz != 0) ed = mq[i][0];
        else if (Byp && in_valid) ed = in_data;
        else ed = '0;
        chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(sz != dep[i]));
        chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(sz != 0 || (Byp && in_valid)));
        chk($sformatf("out_data[%0d]", i), od[i], ed);
        chk($sformatf("occupancy[%0d]", i), 32'(oc[i]), 32'(sz));
      end
    end
  end

  always @(posedge clk) begin
    if (stream_on && ov[1] && out_ready) pops++;
  end

  task automatic cyc(input logic iv, input logic [31:0] d, input logic r, input logic c);
    in_valid  = iv;
    in_data   = d;
    out_ready = r;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_occ", 32'(oc4), 32'd0);
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_out_data", od[0], 32'd0);
    chk("rst_in_ready", 32'(ir[0]), 32'd1);
    rst = 1'b0;
    started = 1'b1;

    // Fill DEPTH=4 with out_ready low, then offer A5 while full.
    for (int k = 1; k <= 4; k++) cyc(1'b1, 32'hA000_0000 + 32'(k), 1'b0, 1'b0);
    chk("fill_occ", 32'(oc4), 32'd4);
    chk("fill_in_ready", 32'(ir[0]), 32'd0);
    chk("fill_head", od[0], 32'hA000_0001);
    chk("fill_occ2", 32'(oc2), 32'd2);
    cyc(1'b1, 32'hA000_0005, 1'b0, 1'b0);
    chk("refused_occ", 32'(oc4), 32'd4);

    // Full + simultaneous pop: only the pop happens, push lands the next cycle.
    cyc(1'b1, 32'hA000_0005, 1'b1, 1'b0);
    chk("fullpop_occ", 32'(oc4), 32'd3);
    chk("fullpop_in_ready", 32'(ir[0]), 32'd1);
    chk("fullpop_head", od[0], 32'hA000_0002);
    cyc(1'b1, 32'hA000_0005, 1'b1, 1'b0);
    chk("pushpop_occ", 32'(oc4), 32'd3);
    chk("pushpop_head", od[0], 32'hA000_0003);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_occ", 32'(oc4), 32'd0);
    chk("drain_valid", 32'(ov[0]), 32'd0);

    // Async reset mid-stream with two entries stored.
    cyc(1'b1, 32'hB000_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'hB000_0002, 1'b0, 1'b0);
    chk("pre_rst_occ", 32'(oc4), 32'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_occ", 32'(oc4), 32'd0);
    chk("mid_rst_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_data", od[0], 32'd0);
    chk("mid_rst_in_ready", 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clear has priority over a same-cycle push.
    for (int k = 1; k <= 3; k++) cyc(1'b1, 32'hC000_0000 + 32'(k), 1'b0, 1'b0);
    chk("pre_clr_occ", 32'(oc4), 32'd3);
    cyc(1'b1, 32'hC000_0004, 1'b0, 1'b1);
    in_valid = 1'b0;
    clear = 1'b0;
    #1;
    chk("clr_occ", 32'(oc4), 32'd0);
    chk("clr_valid", 32'(ov[0]), 32'd0);
    cyc(1'b1, 32'hD000_0001, 1'b0, 1'b0);
    chk("post_clr_head", od[0], 32'hD000_0001);
    chk("post_clr_occ", 32'(oc4), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Empty buffer, word offered with out_ready high.
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    #1;
    chk("byp_same_valid", 32'(ov[0]), 32'(Byp));
    chk("byp_same_data", od[0], Byp ? 32'hDEAD_BEEF : 32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("byp_next_valid", 32'(ov[0]), Byp ? 32'd0 : 32'd1);
    chk("byp_next_occ", 32'(oc4), Byp ? 32'd0 : 32'd1);
    chk("byp_next_data", od[0], Byp ? 32'h0 : 32'hDEAD_BEEF);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Steady stream, payload = counter.
    stream_on = 1'b1;
    for (int k = 0; k < 100; k++) cyc(1'b1, 32'(k), 1'b1, 1'b0);
    stream_on = 1'b0;
    chk("stream_pops", 32'(pops), Byp ? 32'd100 : 32'd99);
    chk("stream_occ2", 32'(oc2), Byp ? 32'd0 : 32'd1);
    chk("stream_head2", od[1], Byp ? 32'd99 : 32'd99);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("end_occ", 32'(oc4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
